// File: rtl/bus_ecc_pkg.sv
// Shared definitions for the 39-bit SEC-DED bus code (encoder and decoder side).
// Holds the code geometry, the data-bit -> Hamming position table, the single
// H-matrix check-bit generator and the small types used by the decoder.
package bus_ecc_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CHK_W  = 7;
  localparam int unsigned CODE_W = DATA_W + CHK_W;
  localparam int unsigned SYN_W  = 6;

  // Hamming position of data bit k: the k-th non-power-of-two integer >= 3.
  localparam logic [SYN_W-1:0] POS [DATA_W] = '{
    6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
    6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
    6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
    6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
  };

  typedef enum logic [1:0] {
    EccClean,
    EccCorrected,
    EccUncorrectable
  } ecc_class_e;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
    logic [SYN_W-1:0]  syn;
    logic              par;
  } stage1_t;

  // Check bit ci = XOR of data bits whose position has bit i set.
  function automatic logic [SYN_W-1:0] gen_check(input logic [DATA_W-1:0] data);
    logic [SYN_W-1:0] c;
    c = '0;
    for (int k = 0; k < DATA_W; k++) begin
      for (int i = 0; i < SYN_W; i++) begin
        if (POS[k][i]) c[i] = c[i] ^ data[k];
      end
    end
    return c;
  endfunction

  // Full codeword: {overall even parity, c5..c0, data}.
  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] data);
    logic [SYN_W-1:0] c;
    c = gen_check(data);
    return {^{c, data}, c, data};
  endfunction

  function automatic logic is_pow2_or_zero(input logic [SYN_W-1:0] v);
    return (v & (v - SYN_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/bus_ecc_decoder_if.sv
// Valid/ready bus bundle for the ECC decoder.
//   in_valid/in_ready/code_in          : codeword input handshake
//   out_valid/out_ready/data_out/flags : corrected data output handshake
// master = upstream/downstream environment, slave = decoder.
interface bus_ecc_decoder_if;
  import bus_ecc_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] code_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] data_out;
  logic              out_corrected;
  logic              out_uncorrectable;

  modport master (
    output in_valid, code_in, out_ready,
    input  in_ready, out_valid, data_out, out_corrected, out_uncorrectable
  );

  modport slave (
    input  in_valid, code_in, out_ready,
    output in_ready, out_valid, data_out, out_corrected, out_uncorrectable
  );

endinterface

// File: rtl/bus_ecc_syndrome.sv
// Combinational syndrome/parity generator.
//   code : received 39-bit codeword
//   syn  : recomputed check bits XOR received check bits
//   par  : XOR of all received bits (1 = odd number of flips)
module bus_ecc_syndrome
  import bus_ecc_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syn,
  output logic              par
);

  assign syn = gen_check(code[DATA_W-1:0]) ^ code[DATA_W+SYN_W-1:DATA_W];
  assign par = ^code;

endmodule

// File: rtl/bus_ecc_decoder.sv
// SEC-DED decoder for the 39-bit bus code with a 2-stage valid/ready pipeline.
//   clk, reset_n  : clock, synchronous active-low reset
//   bus           : codeword in / corrected data + flags out (slave modport)
//   clear_counts  : synchronous clear of both event counters
//   ce_count      : saturating count of corrected words delivered
//   ue_count      : saturating count of uncorrectable words delivered
module bus_ecc_decoder
  import bus_ecc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  bus_ecc_decoder_if.slave    bus,
  input  logic                clear_counts,
  output logic [CNT_W-1:0]    ce_count,
  output logic [CNT_W-1:0]    ue_count
);

  logic [SYN_W-1:0]  syn;
  logic              par;
  stage1_t           s1_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] data_q;
  logic              corr_q;
  logic              unc_q;
  logic [CNT_W-1:0]  ce_q;
  logic [CNT_W-1:0]  ue_q;
  logic              advance;
  logic              handshake;
  ecc_class_e        cls;
  logic [DATA_W-1:0] flip_mask;
  logic [DATA_W-1:0] fixed_data;

  bus_ecc_syndrome u_syndrome (
    .code (bus.code_in),
    .syn  (syn),
    .par  (par)
  );

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance   = !out_valid_q || bus.out_ready;
  assign handshake = out_valid_q && bus.out_ready;

  always_comb begin
    cls       = EccClean;
    flip_mask = '0;
    if (s1_q.par) begin
      if (is_pow2_or_zero(s1_q.syn)) begin
        // Overall parity or a check bit flipped; data is intact.
        cls = EccCorrected;
      end else if (s1_q.syn > SYN_W'(CODE_W - 1)) begin
        cls = EccUncorrectable;
      end else begin
        cls = EccCorrected;
        for (int k = 0; k < DATA_W; k++) begin
          if (POS[k] == s1_q.syn) flip_mask[k] = 1'b1;
        end
      end
    end else if (s1_q.syn != '0) begin
      cls = EccUncorrectable;
    end
    fixed_data = s1_q.code[DATA_W-1:0] ^ flip_mask;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      corr_q      <= 1'b0;
      unc_q       <= 1'b0;
    end else if (advance) begin
      s1_q        <= '{valid: bus.in_valid, code: bus.code_in, syn: syn, par: par};
      out_valid_q <= s1_q.valid;
      data_q      <= s1_q.valid ? fixed_data : '0;
      corr_q      <= s1_q.valid && (cls == EccCorrected);
      unc_q       <= s1_q.valid && (cls == EccUncorrectable);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear_counts) begin
      ce_q <= '0;
      ue_q <= '0;
    end else if (handshake) begin
      if (corr_q && (ce_q != '1)) ce_q <= ce_q + CNT_W'(1);
      if (unc_q && (ue_q != '1)) ue_q <= ue_q + CNT_W'(1);
    end
  end

  assign bus.in_ready          = advance;
  assign bus.out_valid         = out_valid_q;
  assign bus.data_out          = data_q;
  assign bus.out_corrected     = corr_q;
  assign bus.out_uncorrectable = unc_q;
  assign ce_count              = ce_q;
  assign ue_count              = ue_q;

endmodule

// File: tb/tb_bus_ecc_decoder.sv
// Directed bench for bus_ecc_decoder, built with CNT_W=2 so saturation is reachable.
module tb_bus_ecc_decoder;

  logic       clk;
  logic       reset_n;
  logic       clear_counts;
  logic [1:0] ce_count;
  logic [1:0] ue_count;
  int         checks;
  int         errors;

  bus_ecc_decoder_if bus ();

  bus_ecc_decoder #(
    .CNT_W (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus.slave),
    .clear_counts (clear_counts),
    .ce_count     (ce_count),
    .ue_count     (ue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent encoder: the check field is the XOR of the positions of all set data bits.
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [5:0] c;
    int         k;
    c = '0;
    k = 0;
    for (int p = 1; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k]) c = c ^ p[5:0];
        k++;
      end
    end
    return {^{c, d}, c, d};
  endfunction

  function automatic logic [38:0] bit39(input int n);
    logic [38:0] one;
    one = 39'd1;
    return one << n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d,
                           input logic c, input logic u);
    chk({tag, "/valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, "/data"}, 64'(bus.data_out), 64'(d));
    chk({tag, "/corr"}, 64'(bus.out_corrected), 64'(c));
    chk({tag, "/unc"}, 64'(bus.out_uncorrectable), 64'(u));
  endtask

  // One isolated word with out_ready=1: visible exactly 2 cycles after acceptance.
  task automatic xfer(input string tag, input logic [38:0] code, input logic [31:0] d,
                      input logic c, input logic u);
    bus.in_valid = 1'b1;
    bus.code_in  = code;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "/early"}, 64'(bus.out_valid), 64'd0);
    tick();
    check_out(tag, 1'b1, d, c, u);
    tick();
  endtask

  logic [31:0] words [5];
  logic [31:0] sd;

  initial begin
    checks       = 0;
    errors       = 0;
    words        = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000000, 32'h12345678};
    reset_n      = 1'b0;
    clear_counts = 1'b0;
    bus.in_valid = 1'b0;
    bus.code_in  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check_out("reset", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset/ce", 64'(ce_count), 64'd0);
    chk("reset/ue", 64'(ue_count), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("reset/in_ready", 64'(bus.in_ready), 64'd1);

    // Clean back-to-back stream: output i appears while input i+2 is offered.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = (i < 5);
      bus.code_in  = enc(words[i % 5]);
      if (i >= 2) check_out($sformatf("clean%0d", i - 2), 1'b1, words[i - 2], 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("clean/ce", 64'(ce_count), 64'd0);
    chk("clean/ue", 64'(ue_count), 64'd0);

    // Single data-bit errors.
    xfer("d5", enc(32'hDEADBEEF) ^ bit39(5), 32'hDEADBEEF, 1'b1, 1'b0);
    chk("d5/ce", 64'(ce_count), 64'd1);
    xfer("d31", enc(32'hDEADBEEF) ^ bit39(31), 32'hDEADBEEF, 1'b1, 1'b0);
    chk("d31/ce", 64'(ce_count), 64'd2);

    // Check-bit and overall parity errors; third corrected event saturates CNT_W=2.
    xfer("c34", enc(32'hCAFEBABE) ^ bit39(34), 32'hCAFEBABE, 1'b1, 1'b0);
    chk("c34/ce", 64'(ce_count), 64'd3);
    xfer("p38", enc(32'hCAFEBABE) ^ bit39(38), 32'hCAFEBABE, 1'b1, 1'b0);
    chk("p38/ce_sat", 64'(ce_count), 64'd3);
    chk("p38/ue", 64'(ue_count), 64'd0);

    // Double error: raw data passes through (0x21 with bits 0 and 7 flipped is 0xA0).
    xfer("dbl", enc(32'h87654321) ^ bit39(0) ^ bit39(7), 32'h876543A0, 1'b0, 1'b1);
    chk("dbl/ue", 64'(ue_count), 64'd1);
    chk("dbl/ce", 64'(ce_count), 64'd3);

    // Clear coincident with a corrected handshake: clear wins.
    clear_counts = 1'b1;
    xfer("clr", enc(32'h0F0F0F0F) ^ bit39(12), 32'h0F0F0F0F, 1'b1, 1'b0);
    clear_counts = 1'b0;
    chk("clr/ce", 64'(ce_count), 64'd0);
    chk("clr/ue", 64'(ue_count), 64'd0);

    // Five corrected words saturate at 3.
    for (int i = 0; i < 5; i++) begin
      sd = 32'h10000001 * 32'(i + 1);
      xfer($sformatf("sat%0d", i), enc(sd) ^ bit39(i * 6), sd, 1'b1, 1'b0);
    end
    chk("sat/ce", 64'(ce_count), 64'd3);

    // Backpressure.
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    chk("bp/ce0", 64'(ce_count), 64'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.code_in   = enc(32'h11111111) ^ bit39(3);
    tick();
    bus.code_in   = enc(32'h22222222);
    tick();
    bus.code_in   = enc(32'h33333333);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bp%0d/in_ready", i), 64'(bus.in_ready), 64'd0);
      check_out($sformatf("bp%0d", i), 1'b1, 32'h11111111, 1'b1, 1'b0);
      chk($sformatf("bp%0d/ce", i), 64'(ce_count), 64'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp/release_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    check_out("bp/w1", 1'b1, 32'h22222222, 1'b0, 1'b0);
    chk("bp/ce1", 64'(ce_count), 64'd1);
    tick();
    check_out("bp/w2", 1'b1, 32'h33333333, 1'b0, 1'b0);
    tick();
    chk("bp/drained", 64'(bus.out_valid), 64'd0);
    chk("bp/ce_end", 64'(ce_count), 64'd1);

    // Reset with words in both stages: nothing emitted, nothing counted.
    bus.in_valid = 1'b1;
    bus.code_in  = enc(32'h44444444) ^ bit39(1);
    tick();
    bus.code_in  = enc(32'h55555555) ^ bit39(2);
    tick();
    chk("rst/pre_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    tick();
    check_out("rst", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst/ce", 64'(ce_count), 64'd0);
    chk("rst/ue", 64'(ue_count), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst/in_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst/quiet%0d", i), 64'(bus.out_valid), 64'd0);
    end
    chk("rst/ce_end", 64'(ce_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bus_ecc_decoder.md
Name: bus_ecc_decoder

Overview:
- Receive side of the 39-bit ECC-protected high-speed bus.
- Sits directly downstream of the bus ECC encoder stage and consumes its 39-bit codewords (32 data bits + 7 check bits).
- Performs SEC-DED: corrects single-bit errors, flags double-bit errors, and delivers 32-bit data through a 2-stage valid/ready pipeline.
- Keeps saturating corrected/uncorrectable event counters for status.

Parameters:
- CNT_W, 16, width of each error event counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  code_in is valid this cycle.
- in_ready  output  1  decoder accepts code_in this cycle.
- code_in  input  39  codeword: [31:0] data, [37:32] Hamming check c0..c5, [38] overall parity.
- out_valid  output  1  data_out and flags are valid.
- out_ready  input  1  downstream accepts the output.
- data_out  output  32  corrected data.
- out_corrected  output  1  a single-bit error was corrected (data or check bit).
- out_uncorrectable  output  1  a double or invalid-syndrome error was detected; data_out is the raw data.
- clear_counts  input  1  synchronous clear of both counters.
- ce_count  output  CNT_W  corrected-event count, saturating.
- ue_count  output  CNT_W  uncorrectable-event count, saturating.

Behaviour:
- Code layout:
  - Data bit k occupies Hamming position pos(k), the k-th non-power-of-two integer ≥3 (data0→3, data1→5, data2→6, data3→7, data4→9, …, data31→38).
  - Check bit ci = XOR of data bits whose pos has bit i set.
  - code_in[38] = XOR of data[31:0] and c0..c5 (even overall parity).
- Syndrome and parity:
  - Stage 1: s[5:0] = recomputed c XOR received c.
  - p = XOR of all 39 received bits.
- Classification, applied in stage 2:
  - s=0, p=0: clean.
  - p=1, s=0: parity-bit error; corrected=1, data unchanged.
  - p=1, s a power of two: check-bit error; corrected=1, data unchanged.
  - p=1, s = pos(k): flip data bit k; corrected=1.
  - p=1, s>38: uncorrectable=1.
  - p=0, s≠0: uncorrectable=1.
  - corrected and uncorrectable are never both 1.
- Pipeline:
  - advance = !out_valid || out_ready; in_ready = advance (combinational).
  - When advance, stage1 loads {in_valid, code_in, s, p} and stage2 loads from stage1.
  - When !advance, both stages hold.
  - Latency is 2 cycles from input handshake to out_valid with no stall. Throughput is 1/cycle.
  - Bubbles propagate as invalid entries.
- Output hold:
  - While out_valid && !out_ready, data_out and both flags remain stable.
- Counters:
  - Update only on the output handshake (out_valid && out_ready).
  - ce_count +1 if out_corrected; ue_count +1 if out_uncorrectable.
  - Each counter saturates at 2^CNT_W-1 with no wrap.
  - clear_counts wins over a same-cycle increment; the result is 0.
- Reset (reset_n=0 at rising edge):
  - out_valid=0, data_out=0, out_corrected=0, out_uncorrectable=0, ce_count=0, ue_count=0, stage1 valid=0.
  - in_ready reads 1 once reset is released.
- Reset mid-operation:
  - In-flight words are discarded and not counted.
- Flags with no valid output:
  - Flags are don't-care while out_valid=0, but the implementation drives them 0.

Decomposition:
- Shared package bus_ecc_pkg:
  - DATA_W=32, CHK_W=7, CODE_W=39.
  - The pos(k) position table.
  - A check-bit generation function shared with the encoder, so both sides use one H-matrix definition.
- Sub-module bus_ecc_syndrome (combinational): code_in → s[5:0], p.
- Correction, pipeline and counters live in the top module.

Test Plan:
- Clean stream: golden encodings of A5A5A5A5, 5A5A5A5A, FFFFFFFF, 00000000, 12345678, out_ready=1 → same data out 2 cycles after each accept; flags 0; counts stay 0.
- Single data-bit error: DEADBEEF codeword with bit 5 flipped → data_out=DEADBEEF, corrected=1, ce_count=1. Repeat with bit 31 flipped → ce_count=2.
- Check/parity errors: CAFEBABE codeword with bit 34 flipped, then with bit 38 flipped → data CAFEBABE, corrected=1 both times; ue_count=0.
- Double error: 87654321 codeword with bits 0 and 7 flipped → uncorrectable=1, data_out=raw data, ue_count=1.
- Backpressure: hold out_ready=0 for 4 cycles with in_valid=1 → in_ready=0, output stable, no data loss or duplication, counters unchanged until the handshake.
- Saturation/clear/reset: CNT_W=2, 5 corrected words → ce_count=3. clear_counts coincident with an error handshake → 0. reset_n=0 mid-stream → all outputs 0, in-flight word never emitted.
